// File: rtl/controlador_elevador.sv
// controlador_elevador
// Motion controller for the elevator car. Moves the car one floor per trip
// under SCAN scheduling: keeps the current direction while requests remain
// ahead, stops at requested floors, holds the door open for a fixed time and
// pulses a one-cycle clear of the served floor back to the request register.
//
// Parameters:
//   T_ANDAR  cycles of motor drive per floor (>= 1)
//   T_PORTA  cycles the door stays open (>= 1)
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   botao[15:0]   pending requests, bit i = floor i requested
//   subida        some request above the current floor (derived from andar)
//   descida       some request below the current floor (derived from andar)
//   andar[3:0]    current floor, registered, fed back to the detectors
//   motor_sobe    drive car up
//   motor_desce   drive car down
//   porta_aberta  door open
//   limpa[15:0]   one-hot, one-cycle clear of the served floor's request
module controlador_elevador #(
    parameter int T_ANDAR = 8,
    parameter int T_PORTA = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] botao,
    input  logic        subida,
    input  logic        descida,
    output logic [3:0]  andar,
    output logic        motor_sobe,
    output logic        motor_desce,
    output logic        porta_aberta,
    output logic [15:0] limpa
);

    localparam int T_MAX = (T_ANDAR > T_PORTA) ? T_ANDAR : T_PORTA;
    localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [CW-1:0] CARGA_ANDAR = CW'(T_ANDAR - 1);
    localparam logic [CW-1:0] CARGA_PORTA = CW'(T_PORTA - 1);
    localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
    localparam logic [CW-1:0] CNT_UM      = CW'(1);

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        SUBINDO  = 2'd1,
        DESCENDO = 2'd2,
        PORTA    = 2'd3
    } estado_t;

    typedef enum logic {
        DIR_DESCE = 1'b0,
        DIR_SOBE  = 1'b1
    } dir_t;

    estado_t        estado_r;
    estado_t        estado_s;
    dir_t           dir_r;
    dir_t           dir_s;
    logic [3:0]     andar_r;
    logic [3:0]     andar_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  cnt_s;
    logic [15:0]    limpa_r;
    logic [15:0]    limpa_s;
    logic           motor_sobe_r;
    logic           motor_desce_r;
    logic           porta_r;

    logic           pedido_aqui_s;
    logic           sobe_ok_s;
    logic           desce_ok_s;
    logic [15:0]    um_quente_s;

    // One-hot decode of a floor number into the request-clear vector.
    function automatic logic [15:0] decod_andar(input logic [3:0] a);
        decod_andar = 16'd1 << a;
    endfunction

    // Request at the current floor, and move permissions with the floor
    // saturated at both ends so a stuck-high flag can never wrap andar.
    always_comb begin
        pedido_aqui_s = botao[andar_r];
        sobe_ok_s     = subida  && (andar_r != 4'd15);
        desce_ok_s    = descida && (andar_r != 4'd0);
        um_quente_s   = decod_andar(andar_r);
    end

    // Next-state, direction, floor, counter and clear-pulse decision.
    always_comb begin
        estado_s = estado_r;
        dir_s    = dir_r;
        andar_s  = andar_r;
        cnt_s    = cnt_r;
        limpa_s  = 16'd0;
        case (estado_r)
            PARADO: begin
                if (pedido_aqui_s) begin
                    estado_s = PORTA;
                    cnt_s    = CARGA_PORTA;
                    limpa_s  = um_quente_s;
                end else if ((dir_r == DIR_SOBE) && sobe_ok_s) begin
                    estado_s = SUBINDO;
                    cnt_s    = CARGA_ANDAR;
                end else if ((dir_r == DIR_DESCE) && desce_ok_s) begin
                    estado_s = DESCENDO;
                    cnt_s    = CARGA_ANDAR;
                end else if (sobe_ok_s) begin
                    estado_s = SUBINDO;
                    cnt_s    = CARGA_ANDAR;
                    dir_s    = DIR_SOBE;
                end else if (desce_ok_s) begin
                    estado_s = DESCENDO;
                    cnt_s    = CARGA_ANDAR;
                    dir_s    = DIR_DESCE;
                end else begin
                    estado_s = PARADO;
                end
            end
            SUBINDO: begin
                // The trip always completes; botao is ignored while moving.
                if (cnt_r == CNT_ZERO) begin
                    estado_s = PARADO;
                    andar_s  = andar_r + 4'd1;
                end else begin
                    cnt_s = cnt_r - CNT_UM;
                end
            end
            DESCENDO: begin
                if (cnt_r == CNT_ZERO) begin
                    estado_s = PARADO;
                    andar_s  = andar_r - 4'd1;
                end else begin
                    cnt_s = cnt_r - CNT_UM;
                end
            end
            PORTA: begin
                // While limpa is high the request register has not yet
                // dropped this floor's bit, so a still-set bit in that cycle
                // is the request just served, not a new press.
                if (pedido_aqui_s && (limpa_r == 16'd0)) begin
                    cnt_s   = CARGA_PORTA;
                    limpa_s = um_quente_s;
                end else if (cnt_r == CNT_ZERO) begin
                    estado_s = PARADO;
                end else begin
                    cnt_s = cnt_r - CNT_UM;
                end
            end
            default: begin
                estado_s = PARADO;
                cnt_s    = CNT_ZERO;
            end
        endcase
    end

    // State, direction, floor, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r      <= PARADO;
            dir_r         <= DIR_SOBE;
            andar_r       <= 4'd0;
            cnt_r         <= CNT_ZERO;
            limpa_r       <= 16'd0;
            motor_sobe_r  <= 1'b0;
            motor_desce_r <= 1'b0;
            porta_r       <= 1'b0;
        end else begin
            estado_r      <= estado_s;
            dir_r         <= dir_s;
            andar_r       <= andar_s;
            cnt_r         <= cnt_s;
            limpa_r       <= limpa_s;
            motor_sobe_r  <= (estado_s == SUBINDO);
            motor_desce_r <= (estado_s == DESCENDO);
            porta_r       <= (estado_s == PORTA);
        end
    end

    assign andar        = andar_r;
    assign motor_sobe   = motor_sobe_r;
    assign motor_desce  = motor_desce_r;
    assign porta_aberta = porta_r;
    assign limpa        = limpa_r;

endmodule

// File: tb/tb_controlador_elevador.sv
`timescale 1ns/1ps
module tb_controlador_elevador;

    localparam int TA = 4;
    localparam int TP = 6;

    localparam int EV_RUN   = 0;
    localparam int EV_ANDAR = 1;
    localparam int EV_LIMPA = 2;

    localparam int M_IDLE  = 0;
    localparam int M_SOBE  = 1;
    localparam int M_DESCE = 2;
    localparam int M_PORTA = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] botao;
    logic [15:0] pedido;
    logic        force_sub;
    logic        force_des;
    logic        subida;
    logic        descida;
    logic [3:0]  andar;
    logic        motor_sobe;
    logic        motor_desce;
    logic        porta_aberta;
    logic [15:0] limpa;

    // kind, a, b, c ; c = -1 means "any"
    typedef struct {
        int kind;
        int a;
        int b;
        int c;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    int         prev_mode = 0;
    int         run_len   = 0;
    int         idle_len  = 0;
    int         run_gap   = 0;
    logic [3:0] prev_andar = 4'd0;

    always #5 clk = ~clk;

    controlador_elevador #(.T_ANDAR(TA), .T_PORTA(TP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .botao        (botao),
        .subida       (subida),
        .descida      (descida),
        .andar        (andar),
        .motor_sobe   (motor_sobe),
        .motor_desce  (motor_desce),
        .porta_aberta (porta_aberta),
        .limpa        (limpa)
    );

    // Upstream request register: presses set bits, limpa clears them.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) botao <= 16'd0;
        else        botao <= (botao & ~limpa) | pedido;
    end

    // Upstream direction detectors, with override for the boundary cases.
    always_comb begin
        subida  = force_sub;
        descida = force_des;
        for (int i = 0; i < 16; i++) begin
            if (botao[i] && (i > int'(andar))) subida  = 1'b1;
            if (botao[i] && (i < int'(andar))) descida = 1'b1;
        end
    end

    task automatic cmp(input string nome, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nome, got, req);
        end
    endtask

    function automatic void push(input int k, input int a, input int b, input int c);
        ev_t e;
        e.kind = k; e.a = a; e.b = b; e.c = c;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_step(input int mode, input int floor, input int gap);
        push(EV_RUN, mode, TA, gap);
        push(EV_ANDAR, floor, 0, 0);
    endfunction

    function automatic void exp_door(input int floor, input int gap);
        push(EV_LIMPA, 1 << floor, 0, 0);
        push(EV_RUN, M_PORTA, TP, gap);
    endfunction

    task automatic check_ev(input int k, input int a, input int b, input int c);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d c=%0d, required none", k, a, b, c);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a != a || e.b != b || (e.c != -1 && e.c != c)) begin
                n_err++;
                $display("FAIL event: got kind=%0d a=%0d b=%0d c=%0d, required kind=%0d a=%0d b=%0d c=%0d",
                         k, a, b, c, e.kind, e.a, e.b, e.c);
            end
        end
    endtask

    // Sampled on the falling edge: turns output activity into events.
    task automatic mon_step();
        int m;
        if (!rst_n) begin
            prev_mode  = M_IDLE;
            run_len    = 0;
            idle_len   = 0;
            prev_andar = andar;
        end else begin
            m = porta_aberta ? M_PORTA : (motor_desce ? M_DESCE : (motor_sobe ? M_SOBE : M_IDLE));
            cmp("exclusive_outputs", int'(motor_sobe) + int'(motor_desce) + int'(porta_aberta) > 1 ? 1 : 0, 0);
            if (m != prev_mode) begin
                if (prev_mode != M_IDLE) check_ev(EV_RUN, prev_mode, run_len, run_gap);
                if (m != M_IDLE) begin
                    run_gap = (prev_mode == M_IDLE) ? idle_len : 0;
                    run_len = 1;
                end else begin
                    idle_len = 1;
                end
                prev_mode = m;
            end else begin
                if (m == M_IDLE) idle_len++;
                else             run_len++;
            end
            if (andar != prev_andar) begin
                check_ev(EV_ANDAR, int'(andar), 0, 0);
                prev_andar = andar;
            end
            if (limpa != 16'd0) check_ev(EV_LIMPA, int'(limpa), (m == M_PORTA) ? run_len - 1 : -5, 0);
        end
    endtask

    task automatic pulsa(input logic [15:0] v);
        @(negedge clk);
        pedido = v;
        @(negedge clk);
        pedido = 16'd0;
    endtask

    task automatic drain(input int budget, input string nome);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        cmp(nome, exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int k;
        rst_n     = 1'b0;
        pedido    = 16'd0;
        force_sub = 1'b0;
        force_des = 1'b0;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        cmp("reset_andar", int'(andar), 0);
        cmp("reset_motor_sobe", int'(motor_sobe), 0);
        cmp("reset_motor_desce", int'(motor_desce), 0);
        cmp("reset_porta", int'(porta_aberta), 0);
        cmp("reset_limpa", int'(limpa), 0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Request at the current floor: door only, no motor
        exp_door(0, -1);
        pulsa(16'h0001);
        drain(100, "here_door");

        // Single upward trip 0 -> 3
        exp_step(M_SOBE, 1, -1);
        exp_step(M_SOBE, 2, 1);
        exp_step(M_SOBE, 3, 1);
        exp_door(3, 1);
        pulsa(16'h0008);
        drain(200, "trip_up_3");

        // Bring car to 5 moving up
        exp_step(M_SOBE, 4, -1);
        exp_step(M_SOBE, 5, 1);
        exp_door(5, 1);
        pulsa(16'h0020);
        drain(200, "trip_up_5");

        // SCAN: floors 2 and 8 from 5 going up -> 8 first, then 2
        exp_step(M_SOBE, 6, -1);
        exp_step(M_SOBE, 7, 1);
        exp_step(M_SOBE, 8, 1);
        exp_door(8, 1);
        for (int f = 7; f >= 2; f--) exp_step(M_DESCE, f, 1);
        exp_door(2, 1);
        pulsa(16'h0104);
        drain(400, "scan_8_then_2");

        // Direction now down: floors 1 and 4 from 2 -> 1 first
        exp_step(M_DESCE, 1, -1);
        exp_door(1, 1);
        for (int f = 2; f <= 4; f++) exp_step(M_SOBE, f, 1);
        exp_door(4, 1);
        pulsa(16'h0012);
        drain(300, "scan_dir_down");

        // Door extend at floor 4
        push(EV_LIMPA, 16'h0010, 0, 0);
        push(EV_LIMPA, 16'h0010, 5, 0);
        push(EV_RUN, M_PORTA, 5 + TP, -1);
        pulsa(16'h0010);
        k = 0;
        while (porta_aberta !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        cmp("door_open_timeout", int'(porta_aberta === 1'b1), 1);
        repeat (3) @(negedge clk);
        pedido = 16'h0010;
        @(negedge clk);
        pedido = 16'd0;
        drain(100, "door_extend");

        // Up to the top floor, then stuck subida must not move the car
        exp_step(M_SOBE, 5, -1);
        for (int f = 6; f <= 15; f++) exp_step(M_SOBE, f, 1);
        exp_door(15, 1);
        pulsa(16'h8000);
        drain(400, "trip_up_15");
        force_sub = 1'b1;
        repeat (30) @(negedge clk);
        cmp("top_andar", int'(andar), 15);
        cmp("top_motor_sobe", int'(motor_sobe), 0);
        force_sub = 1'b0;
        repeat (2) @(negedge clk);

        // Down to floor 0, then stuck descida must not move the car
        exp_step(M_DESCE, 14, -1);
        for (int f = 13; f >= 0; f--) exp_step(M_DESCE, f, 1);
        exp_door(0, 1);
        pulsa(16'h0001);
        drain(400, "trip_down_0");
        force_des = 1'b1;
        repeat (30) @(negedge clk);
        cmp("bottom_andar", int'(andar), 0);
        cmp("bottom_motor_desce", int'(motor_desce), 0);
        force_des = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of the second floor of a trip
        exp_step(M_SOBE, 1, -1);
        pulsa(16'h0008);
        k = 0;
        while (!(andar == 4'd1 && motor_sobe == 1'b1) && k < 100) begin
            @(negedge clk);
            k++;
        end
        cmp("midtrip_reached", int'(andar == 4'd1 && motor_sobe == 1'b1), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("async_rst_andar", int'(andar), 0);
        cmp("async_rst_motor_sobe", int'(motor_sobe), 0);
        cmp("async_rst_porta", int'(porta_aberta), 0);
        cmp("async_rst_limpa", int'(limpa), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        cmp("events_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
